seq_squarer: RTL and testbench
==============================

# seq_squarer

Parametrised, iterative shift-add squarer: computes p = a × a for an unsigned WIDTH-bit operand in WIDTH clock cycles. It uses a valid/ready handshake on input and output. It is the sequential, width-generic successor to the fixed 6-bit combinational squarer in the arithmetic library. It trades one partial-product row per cycle for an adder array.

## Interface
- WIDTH, default 6: operand width, legal range 2..32
- ACC_WIDTH, default 2*WIDTH+4: accumulator width; only used when SEQ_SQUARER_ACC_EN is defined
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand a is valid
- in_ready  output  1  block can accept an operand; high only in IDLE
- a  input  WIDTH  unsigned operand
- out_valid  output  1  p holds a finished result; high only in DONE
- out_ready  input  1  consumer accepts p
- p  output  2*WIDTH  unsigned square
- acc_clr  input  1  synchronous accumulator clear (SEQ_SQUARER_ACC_EN only)
- acc  output  ACC_WIDTH  running sum of delivered squares (SEQ_SQUARER_ACC_EN only)
- acc_ovf  output  1  sticky accumulator wrap flag (SEQ_SQUARER_ACC_EN only)

## Operation
- The FSM has three states: IDLE, CALC and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready:
    - latch the multiplicand register m=a and the shift register r=a;
    - clear the product register prod=0 and the counter cnt=0;
    - go to CALC.
- CALC, each cycle:
  - if r[0]=1, then prod += m << cnt, computed at 2*WIDTH bits with no overflow possible;
  - shift r right by 1;
  - cnt += 1.
  - When cnt==WIDTH-1 on this cycle, go to DONE.
  - No early termination: every operand takes exactly WIDTH CALC cycles.
- DONE:
  - out_valid=1 and p=prod.
  - p stays stable while out_valid&&!out_ready.
  - On out_valid&&out_ready, go to IDLE.
- p is driven from prod in every state. Its value is defined only while out_valid=1.
- Operand inputs are ignored outside IDLE. The a input is sampled only on the accept edge.
- There is no input-to-output bypass. A new operand is accepted no earlier than the cycle after the output handshake.
- Reset, including reset asserted mid-CALC or mid-DONE, has these effects:
  - state=IDLE, prod=0, r=0, m=0, cnt=0;
  - outputs: in_ready=1, out_valid=0, p=0, acc=0, acc_ovf=0;
  - any in-flight result is discarded.

## Timing
- Latency: out_valid rises WIDTH edges after the accept edge.
- Minimum initiation interval: WIDTH+2 cycles (1 IDLE cycle + WIDTH CALC cycles + 1 DONE cycle), with out_ready held high.
- in_ready and out_valid are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Backpressure: DONE is held indefinitely while out_ready=0, and in_ready stays 0 for that whole time.

## Configuration
- Macro SEQ_SQUARER_ACC_EN, when defined:
  - adds acc_clr, acc and acc_ovf;
  - on each out_valid&&out_ready edge, acc += zero-extended p, modulo 2^ACC_WIDTH;
  - acc_ovf is set, sticky, on a carry out of the MSB;
  - acc_clr clears both acc and acc_ovf on the next edge;
  - acc_clr wins over a simultaneous output handshake: the concurrent p is not added;
  - the acc value becomes visible the cycle after the handshake.
- When SEQ_SQUARER_ACC_EN is undefined:
  - the accumulator ports and logic are absent;
  - behaviour is otherwise identical.

## Structure
- Package seq_squarer_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the localparam helper function for the counter width, clog2(WIDTH).
- One sub-module, sq_shift_add_step, is natural: the combinational CALC-cycle datapath.
  - Inputs: prod, m, r[0], cnt.
  - Output: next prod.
  - Parametrised on WIDTH.
- The FSM, registers and accumulator stay in seq_squarer.

## Test plan
- WIDTH=6, a=0 -> out_valid rises 6 edges after accept, p=0.
- WIDTH=6, a=63 -> p=3969. Then a=45 -> p=2025. Both with out_ready=1; measure an initiation interval of 8 cycles.
- WIDTH=6, a=37, out_ready held low for 5 cycles in DONE -> p=1369 stays stable, in_ready=0 throughout, and in_valid pulses in that window are ignored.
- WIDTH=8, a=255 -> p=65025. Also an exhaustive sweep of a=0..255 checked against a×a.
- Reset asserted on the 3rd CALC cycle of a=50, then released, then a=7 accepted -> out_valid=0 and in_ready=1 immediately after reset, and the next result is p=49 with no residue from the aborted operation.
- SEQ_SQUARER_ACC_EN, WIDTH=6, ACC_WIDTH=13:
  - deliver 63 twice -> acc=7938;
  - a third 63 -> acc=3715 and acc_ovf=1;
  - acc_clr asserted on the same edge as a handshake -> acc=0, acc_ovf=0.

Source files
------------

// File: rtl/seq_squarer_pkg.sv
// -----------------------------------------------------------------------------
// seq_squarer_pkg
// Shared definitions for the iterative shift-add squarer:
//   - state_t   : FSM state encoding (IDLE, CALC, DONE)
//   - cnt_width : width of the bit-position counter for a given operand width
//   - WIDTH_MIN / WIDTH_MAX : legal operand width range
// Optional feature macro used by the top: SEQ_SQUARER_ACC_EN.
// -----------------------------------------------------------------------------
package seq_squarer_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
  // Clamp to one bit so a degenerate width never yields a zero-width vector.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sq_shift_add_step.sv
// -----------------------------------------------------------------------------
// sq_shift_add_step
// Combinational datapath for one CALC cycle of the squarer: adds the
// multiplicand, shifted to the current bit position, into the partial product
// when the current multiplier bit is set.
// Parameters:
//   WIDTH        operand width
// Ports:
//   i_prod       [2*WIDTH-1:0]  current partial product
//   i_m          [WIDTH-1:0]    multiplicand
//   i_r0                        current multiplier bit (LSB of shift register)
//   i_cnt        [CW-1:0]       bit position of i_r0
//   o_prod_next  [2*WIDTH-1:0]  partial product after this cycle
// -----------------------------------------------------------------------------
module sq_shift_add_step
  import seq_squarer_pkg::*;
#(
  parameter  int WIDTH = 6,
  localparam int CW    = cnt_width(WIDTH)
) (
  input  logic [2*WIDTH-1:0] i_prod,
  input  logic [WIDTH-1:0]   i_m,
  input  logic               i_r0,
  input  logic [CW-1:0]      i_cnt,
  output logic [2*WIDTH-1:0] o_prod_next
);

  logic [2*WIDTH-1:0] w_m_ext;
  logic [2*WIDTH-1:0] w_pp;

  // The final sum is a*a < 2^(2*WIDTH), and every intermediate sum is a
  // subset of its partial products, so the 2*WIDTH-bit add never overflows.
  assign w_m_ext     = {{WIDTH{1'b0}}, i_m};
  assign w_pp        = i_r0 ? (w_m_ext << i_cnt) : '0;
  assign o_prod_next = i_prod + w_pp;

endmodule

// File: rtl/seq_squarer.sv
// -----------------------------------------------------------------------------
// seq_squarer
// Iterative shift-add squarer: p = a*a for an unsigned WIDTH-bit operand, one
// partial-product row per cycle, WIDTH CALC cycles per operand.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. in_ready is high only in IDLE, out_valid only in DONE; both are decoded
// from the registered state, so neither depends combinationally on in_valid or
// out_ready. p holds stable while out_valid && !out_ready.
//
// Parameters:
//   WIDTH      operand width (2..32)
//   ACC_WIDTH  accumulator width (used only with SEQ_SQUARER_ACC_EN)
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready/a   operand input handshake
//   out_valid/out_ready/p result output handshake
//   acc_clr, acc, acc_ovf running-sum accumulator (SEQ_SQUARER_ACC_EN only)
// Optional feature macro: SEQ_SQUARER_ACC_EN
// -----------------------------------------------------------------------------
module seq_squarer
  import seq_squarer_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int ACC_WIDTH = 2*WIDTH+4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
`ifdef SEQ_SQUARER_ACC_EN
  ,
  input  logic                 acc_clr,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 acc_ovf
`endif
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

  // Elaboration-time parameter sanity checks.
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("seq_squarer: WIDTH out of range");
  end
  if (ACC_WIDTH < 1) begin : g_bad_acc_width
    $error("seq_squarer: ACC_WIDTH must be positive");
  end

  state_t               r_state;
  state_t               w_state_next;
  logic [WIDTH-1:0]     r_m;
  logic [WIDTH-1:0]     r_r;
  logic [2*WIDTH-1:0]   r_prod;
  logic [CW-1:0]        r_cnt;
  logic [2*WIDTH-1:0]   w_prod_next;
  logic                 w_accept;
  logic                 w_last;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == CNT_LAST);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_state_next = CALC;
      CALC:    if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded from registered state only
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  sq_shift_add_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_prod      (r_prod),
    .i_m         (r_m),
    .i_r0        (r_r[0]),
    .i_cnt       (r_cnt),
    .o_prod_next (w_prod_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m    <= '0;
      r_r    <= '0;
      r_prod <= '0;
      r_cnt  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_m    <= a;
            r_r    <= a;
            r_prod <= '0;
            r_cnt  <= '0;
          end
        end
        CALC: begin
          // No early exit on r==0: fixed WIDTH-cycle latency for every operand.
          r_prod <= w_prod_next;
          r_r    <= r_r >> 1;
          r_cnt  <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign p = r_prod;

`ifdef SEQ_SQUARER_ACC_EN
  // ---------------------------------------------------------------------------
  // Running sum of delivered squares. The extra top bit of the sum is the
  // carry out of the accumulator MSB, which sets the sticky wrap flag.
  // ---------------------------------------------------------------------------
  logic                 w_out_hs;
  logic [ACC_WIDTH:0]   w_acc_sum;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_acc_ovf;

  assign w_out_hs  = out_valid && out_ready;
  assign w_acc_sum = {1'b0, r_acc} + (ACC_WIDTH+1)'(r_prod);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_acc_ovf <= 1'b0;
    end else if (acc_clr) begin
      // Clear takes priority; a result delivered on this edge is dropped.
      r_acc     <= '0;
      r_acc_ovf <= 1'b0;
    end else if (w_out_hs) begin
      r_acc <= w_acc_sum[ACC_WIDTH-1:0];
      if (w_acc_sum[ACC_WIDTH]) begin
        r_acc_ovf <= 1'b1;
      end
    end
  end

  assign acc     = r_acc;
  assign acc_ovf = r_acc_ovf;
`endif

endmodule

// File: tb/tb_seq_squarer.sv
// -----------------------------------------------------------------------------
// tb_seq_squarer
// Directed bench for seq_squarer: a WIDTH=6 instance (ACC_WIDTH=13) for the
// timing, backpressure, reset and accumulator scenarios, and a WIDTH=8
// instance for the full operand sweep. Inputs change #1 after the rising edge
// and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_seq_squarer;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  logic        in_valid6, in_ready6, out_valid6, out_ready6;
  logic [5:0]  a6;
  logic [11:0] p6;
  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8;
  logic [15:0] p8;
`ifdef SEQ_SQUARER_ACC_EN
  logic        acc_clr6, acc_ovf6, acc_clr8, acc_ovf8;
  logic [12:0] acc6;
  logic [19:0] acc8;
`endif

  seq_squarer #(.WIDTH(6), .ACC_WIDTH(13)) dut6 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid6),
    .in_ready  (in_ready6),
    .a         (a6),
    .out_valid (out_valid6),
    .out_ready (out_ready6),
    .p         (p6)
`ifdef SEQ_SQUARER_ACC_EN
    ,
    .acc_clr   (acc_clr6),
    .acc       (acc6),
    .acc_ovf   (acc_ovf6)
`endif
  );

  seq_squarer #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid8),
    .in_ready  (in_ready8),
    .a         (a8),
    .out_valid (out_valid8),
    .out_ready (out_ready8),
    .p         (p8)
`ifdef SEQ_SQUARER_ACC_EN
    ,
    .acc_clr   (acc_clr8),
    .acc       (acc8),
    .acc_ovf   (acc_ovf8)
`endif
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer an operand and return the cycle stamp of the accept edge. The
  // operand bus is scrambled afterwards: it must only be sampled on accept.
  task automatic send6(input logic [5:0] av, output int t_acc);
    int n;
    n = 0;
    while (!in_ready6 && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready6) check("accept6_timeout", 32'd0, 32'd1);
    in_valid6 = 1'b1;
    a6        = av;
    tick();
    t_acc     = cyc;
    in_valid6 = 1'b0;
    a6        = 6'($urandom_range(0, 63));
  endtask

  task automatic wait_done6(output int t_done);
    int n;
    n = 0;
    while (!out_valid6 && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid6) check("done6_timeout", 32'd0, 32'd1);
    t_done = cyc;
  endtask

  task automatic run8(input int av, input string tag, input bit chk_lat);
    int n;
    int t_acc;
    n = 0;
    while (!in_ready8 && n < 40) begin
      tick();
      n++;
    end
    if (!in_ready8) check("accept8_timeout", 32'd0, 32'd1);
    in_valid8 = 1'b1;
    a8        = 8'(av);
    tick();
    t_acc     = cyc;
    in_valid8 = 1'b0;
    a8        = 8'($urandom_range(0, 255));
    n = 0;
    while (!out_valid8 && n < 40) begin
      tick();
      n++;
    end
    if (!out_valid8) check("done8_timeout", 32'd0, 32'd1);
    if (chk_lat) check({tag, "_latency"}, 32'(cyc - t_acc), 32'd8);
    check(tag, 32'(p8), 32'(av * av));
    tick();  // out_ready8 is high: handshake on this edge
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int ta, ta2, td;

    rst_n      = 1'b0;
    in_valid6  = 1'b0;
    a6         = '0;
    out_ready6 = 1'b1;
    in_valid8  = 1'b0;
    a8         = '0;
    out_ready8 = 1'b1;
`ifdef SEQ_SQUARER_ACC_EN
    acc_clr6   = 1'b0;
    acc_clr8   = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready6), 32'd1);
    check("rst_out_valid", 32'(out_valid6), 32'd0);
    check("rst_p", 32'(p6), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // a=0: latency of 6 edges, p=0
    send6(6'd0, ta);
    wait_done6(td);
    check("zero_latency", 32'(td - ta), 32'd6);
    check("zero_p", 32'(p6), 32'd0);
    tick();
    check("zero_out_valid_after_hs", 32'(out_valid6), 32'd0);

    // 63 then 45 back to back: initiation interval of 8
    send6(6'd63, ta);
    wait_done6(td);
    check("p_63", 32'(p6), 32'd3969);
    tick();
    send6(6'd45, ta2);
    check("init_interval", 32'(ta2 - ta), 32'd8);
    wait_done6(td);
    check("latency_45", 32'(td - ta2), 32'd6);
    check("p_45", 32'(p6), 32'd2025);
    tick();

    // Backpressure: 5 cycles in DONE with out_ready low, in_valid pulsing
    out_ready6 = 1'b0;
    send6(6'd37, ta);
    wait_done6(td);
    check("p_37", 32'(p6), 32'd1369);
    for (int i = 0; i < 5; i++) begin
      in_valid6 = (i % 2 == 0);
      a6        = 6'(i * 3 + 1);
      tick();
      check("bp_in_ready", 32'(in_ready6), 32'd0);
      check("bp_out_valid", 32'(out_valid6), 32'd1);
      check("bp_p_stable", 32'(p6), 32'd1369);
    end
    in_valid6  = 1'b0;
    out_ready6 = 1'b1;
    tick();
    check("bp_release_out_valid", 32'(out_valid6), 32'd0);
    check("bp_release_in_ready", 32'(in_ready6), 32'd1);
    tick();
    check("bp_no_phantom_op", 32'(in_ready6), 32'd1);
    send6(6'd2, ta);
    wait_done6(td);
    check("p_2_after_bp", 32'(p6), 32'd4);
    tick();

    // Reset in the 3rd CALC cycle of a=50
    send6(6'd50, ta);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready6), 32'd1);
    check("midrst_out_valid", 32'(out_valid6), 32'd0);
    check("midrst_p", 32'(p6), 32'd0);
`ifdef SEQ_SQUARER_ACC_EN
    check("midrst_acc", 32'(acc6), 32'd0);
    check("midrst_acc_ovf", 32'(acc_ovf6), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send6(6'd7, ta);
    wait_done6(td);
    check("post_rst_latency", 32'(td - ta), 32'd6);
    check("post_rst_p_7", 32'(p6), 32'd49);
    tick();

`ifdef SEQ_SQUARER_ACC_EN
    // Accumulator, ACC_WIDTH=13 (modulo 8192); it currently holds 49
    acc_clr6 = 1'b1;
    tick();
    acc_clr6 = 1'b0;
    check("acc_cleared", 32'(acc6), 32'd0);
    send6(6'd63, ta);
    wait_done6(td);
    tick();
    check("acc_63x1", 32'(acc6), 32'd3969);
    send6(6'd63, ta);
    wait_done6(td);
    tick();
    check("acc_63x2", 32'(acc6), 32'd7938);
    check("acc_ovf_63x2", 32'(acc_ovf6), 32'd0);
    send6(6'd63, ta);
    wait_done6(td);
    tick();
    check("acc_63x3_wrap", 32'(acc6), 32'd3715);
    check("acc_ovf_63x3", 32'(acc_ovf6), 32'd1);
    // Clear on the same edge as a handshake: the 25 is not added
    out_ready6 = 1'b0;
    send6(6'd5, ta);
    wait_done6(td);
    acc_clr6   = 1'b1;
    out_ready6 = 1'b1;
    tick();
    acc_clr6   = 1'b0;
    check("acc_clr_vs_hs", 32'(acc6), 32'd0);
    check("acc_ovf_clr_vs_hs", 32'(acc_ovf6), 32'd0);
    check("acc_clr_hs_done", 32'(out_valid6), 32'd0);
`endif

    // WIDTH=8: directed maximum, then the full sweep
    run8(255, "w8_p_255", 1'b1);
    for (int v = 0; v < 256; v++) begin
      run8(v, "w8_sweep", 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
